// File: rtl/iq_avg_seq_ctrl.sv
// Sequencer for an I/Q frame averager: clears the accumulators, gates accumulation
// over 2^n frames, then sweeps the snapshot BRAM once per channel.
module iq_avg_seq_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int MAX_LOG2 = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_word,
  input  logic              frame_sync,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [3:0]        avg_shift,
  output logic              snap_we,
  output logic [ADDR_W-1:0] snap_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_word
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_SYNC = 3'd2,
    ACC       = 3'd3,
    DUMP      = 3'd4
  } state_t;

  localparam logic [3:0]        MAX_SHIFT = 4'(MAX_LOG2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t      state;
  logic        arm_q;
  logic        arm_live;
  logic [15:0] frame_cnt;

  logic        arm_edge;
  logic        abort;
  logic [3:0]  shift_req;
  logic [15:0] frame_target;
  logic        unused_ctrl_bits;

  // arm_live masks the first cycle after reset so an arm bit already high is not an edge
  assign arm_edge     = ctrl_word[0] & ~arm_q & arm_live;
  assign abort        = ctrl_word[1];
  assign shift_req    = (ctrl_word[7:4] > MAX_SHIFT) ? MAX_SHIFT : ctrl_word[7:4];
  assign frame_target = 16'd1 << avg_shift;
  assign unused_ctrl_bits = ^{ctrl_word[31:8], ctrl_word[3:2]};

  assign status_word = {frame_cnt, avg_shift, 1'b0, state, 6'b0, done, busy};

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= IDLE;
      arm_q     <= 1'b0;
      arm_live  <= 1'b0;
      frame_cnt <= 16'd0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      avg_shift <= 4'd0;
      snap_we   <= 1'b0;
      snap_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      arm_q    <= ctrl_word[0];
      arm_live <= 1'b1;
      acc_clr  <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        acc_en  <= 1'b0;
        snap_we <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_edge) begin
              avg_shift <= shift_req;
              frame_cnt <= 16'd0;
              done      <= 1'b0;
              acc_clr   <= 1'b1;
              busy      <= 1'b1;
              state     <= CLEAR;
            end
          end
          CLEAR: state <= WAIT_SYNC;
          WAIT_SYNC: begin
            if (frame_sync) begin
              acc_en <= 1'b1;
              state  <= ACC;
            end
          end
          ACC: begin
            if (frame_sync) begin
              frame_cnt <= frame_cnt + 16'd1;
              // the sync that closes the last frame also opens the dump
              if (frame_cnt + 16'd1 == frame_target) begin
                acc_en    <= 1'b0;
                snap_we   <= 1'b1;
                snap_addr <= '0;
                state     <= DUMP;
              end
            end
          end
          DUMP: begin
            if (snap_addr == LAST_ADDR) begin
              snap_we <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              snap_addr <= snap_addr + ADDR_W'(1);
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iq_avg_seq_ctrl.sv
// Bench for iq_avg_seq_ctrl with 8-channel frames and frame_sync every 8 cycles.
// Per-sequence summaries and dump addresses are checked against expected queues.
module tb_iq_avg_seq_ctrl;

  localparam int ADDR_W = 3;
  localparam int SEQ_W  = 56;

  logic              clk;
  logic              rst_n;
  logic [31:0]       ctrl;
  logic              frame_sync;
  logic              acc_clr;
  logic              acc_en;
  logic [3:0]        avg_shift;
  logic              snap_we;
  logic [ADDR_W-1:0] snap_addr;
  logic              busy;
  logic              done;
  logic [31:0]       status_word;

  iq_avg_seq_ctrl #(.ADDR_W(ADDR_W), .MAX_LOG2(10)) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .ctrl_word   (ctrl),
    .frame_sync  (frame_sync),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .avg_shift   (avg_shift),
    .snap_we     (snap_we),
    .snap_addr   (snap_addr),
    .busy        (busy),
    .done        (done),
    .status_word (status_word)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int phase = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [SEQ_W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    phase      = (phase + 1) % 8;
    frame_sync = (phase == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int a);
    for (int i = 0; i < 8 && phase != a; i++) step();
  endtask

  task automatic arm(input logic [3:0] n);
    ctrl = {24'd0, n, 4'h1};
    step();
    ctrl = {24'd0, n, 4'h0};
  endtask

  task automatic expect_seq(input int lat, input int acc, input int frm, input int shift);
    logic [SEQ_W-1:0] w;
    w = {8'(lat), 8'd8, 16'(acc), 16'(frm), 4'(shift), 4'd1};
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(ADDR_W'(i));
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    check(name, 64'(done), 64'd1);
  endtask

  // monitor / scoreboard
  initial begin
    int lat_cnt = 0;
    int snap_cnt = 0;
    int acc_cnt = 0;
    int clr_cnt = 0;
    logic done_d = 1'b0;
    logic [ADDR_W-1:0] ea;
    logic [SEQ_W-1:0]  got;
    logic [SEQ_W-1:0]  ew;
    forever begin
      @(negedge clk);
      if (snap_we) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_snap_we: got addr %0d expected no write", snap_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (snap_addr !== ea) begin
            fails++;
            $display("FAIL snap_addr: got %0d expected %0d", snap_addr, ea);
          end
        end
        snap_cnt++;
      end
      if (acc_en) acc_cnt++;
      if (acc_clr) clr_cnt++;
      if (busy && !acc_en && acc_cnt == 0) lat_cnt++;
      if (done && !done_d) begin
        got = {8'(lat_cnt), 8'(snap_cnt), 16'(acc_cnt), status_word[31:16], avg_shift, 4'(clr_cnt)};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got summary %0h expected none", got);
        end else begin
          ew = exp_q.pop_front();
          if (got !== ew) begin
            fails++;
            $display("FAIL seq_summary: got %0h expected %0h", got, ew);
          end
        end
      end
      done_d = done;
      if (!busy) begin
        lat_cnt  = 0;
        snap_cnt = 0;
        acc_cnt  = 0;
        clr_cnt  = 0;
      end
    end
  end

  // stimulus
  initial begin
    rst_n      = 1'b1;
    ctrl       = 32'h1;
    frame_sync = 1'b0;
    #1 rst_n = 1'b0;
    steps(3);
    rst_n = 1'b0;
    check("reset_outputs", 64'({acc_clr, acc_en, snap_we, busy, done, snap_addr, avg_shift}), 64'd0);
    check("reset_status", 64'(status_word), 64'd0);
    rst_n = 1'b1;
    steps(6);
    check("held_arm_no_start", 64'(busy), 64'd0);
    ctrl = 32'h0;
    steps(2);

    // n=2, arm so that frame_sync lands in CLEAR; ACC waits for the next sync
    wait_phase(7);
    expect_seq(9, 32, 4, 2);
    arm(4'd2);
    wait_done("done_n2", 200);
    check("status_n2", 64'(status_word), 64'h0004_2002);
    steps(5);
    check("done_sticky", 64'(status_word), 64'h0004_2002);

    // n=0 accumulates a single frame
    wait_phase(3);
    expect_seq(5, 8, 1, 0);
    arm(4'd0);
    wait_done("done_n0", 100);

    // n=15 clamps to 10
    wait_phase(0);
    expect_seq(8, 8192, 1024, 10);
    arm(4'd15);
    wait_done("done_n15", 9000);
    check("status_n15", 64'(status_word), 64'h0400_A002);

    // abort mid-ACC
    wait_phase(3);
    arm(4'd1);
    for (int i = 0; i < 40 && !acc_en; i++) step();
    check("abort_acc_started", 64'(acc_en), 64'd1);
    steps(4);
    ctrl = 32'h12;
    step();
    check("abort_outputs", 64'({acc_en, snap_we, busy, done, status_word[10:8]}), 64'd0);
    step();
    ctrl = 32'h13;
    step();
    check("abort_beats_arm", 64'({busy, acc_clr}), 64'd0);
    ctrl = 32'h0;
    steps(24);
    check("abort_stays_idle", 64'({busy, done}), 64'd0);

    // second arm edge during ACC is ignored
    wait_phase(3);
    expect_seq(5, 16, 2, 1);
    arm(4'd1);
    for (int i = 0; i < 40 && !acc_en; i++) step();
    steps(3);
    ctrl = 32'h31;
    steps(2);
    ctrl = 32'h30;
    wait_done("done_rearm", 100);

    // reset pulsed mid-DUMP
    wait_phase(3);
    expect_seq(5, 8, 1, 0);
    exp_q.delete();
    arm(4'd0);
    for (int i = 0; i < 40 && !snap_we; i++) step();
    check("dump_started", 64'(snap_we), 64'd1);
    steps(3);
    rst_n = 1'b0;
    #1;
    check("mid_dump_reset_outputs", 64'({acc_clr, acc_en, snap_we, busy, done, snap_addr, avg_shift}), 64'd0);
    check("mid_dump_reset_status", 64'(status_word), 64'd0);
    exp_addr_q.delete();
    ctrl = 32'h1;
    steps(3);
    rst_n = 1'b1;
    steps(20);
    check("post_reset_idle", 64'({busy, done}), 64'd0);
    ctrl = 32'h0;
    step();
    wait_phase(3);
    expect_seq(5, 8, 1, 0);
    arm(4'd0);
    wait_done("done_after_reset", 100);

    steps(12);
    check("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    check("seq_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
